// File: rtl/tm_sch_pkg.sv
// ============================================================================
// Module : tm_sch_pkg
// Brief  : Shared types and defaults for the third-level TM scheduler
//          priority selector (queue/scheduler id widths, control word,
//          selector FSM states).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tm_sch_pkg;

    localparam int TM_QID_NBITS = 8;
    localparam int TM_SCH_NBITS = 4;

    // Default number of cycles to wait for the control memory to answer.
    localparam int TM_SEL_ACK_TIMEOUT = 64;

    typedef logic [TM_QID_NBITS-1:0] qid_t;
    typedef logic [TM_SCH_NBITS-1:0] sch_id_t;

    // Control word as stored in the priority scheduler control memory.
    typedef struct packed {
        qid_t qid_hi;
        qid_t qid_lo;
    } pri_ctrl_t;

    // Selector FSM states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_CALC = 3'd3,
        S_OUT  = 3'd4
    } sel_state_e;

endpackage

`default_nettype wire

// File: rtl/tm_sch_rr_ptr_ram.sv
// ============================================================================
// Module : tm_sch_rr_ptr_ram
// Brief  : Round-robin last-served pointer store, one entry per scheduler.
//          1R1W with registered read; a separate valid-bit vector is cleared
//          by reset so stale pointers are never trusted. A same-address
//          read and write in one cycle returns the old data.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tm_sch_rr_ptr_ram #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o,
    output logic          rvld_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);

    localparam int c_depth = 1 << AW;

    logic [DW-1:0]      mem_q [c_depth];
    logic [DW-1:0]      rdata_q;
    logic [c_depth-1:0] vld_q;
    logic               rvld_q;

    // Pointer storage: plain memory, no reset, registered read port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    // Valid bits: cleared by reset, set on first write, read alongside data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            rvld_q <= 1'b0;
        end else begin
            if (rd_en_i) begin
                rvld_q <= vld_q[raddr_i];
            end
            if (we_i) begin
                vld_q[waddr_i] <= 1'b1;
            end
        end
    end

    assign rdata_o = rdata_q;
    assign rvld_o  = rvld_q;

endmodule

`default_nettype wire

// File: rtl/tm_sch_pri_sel.sv
// ============================================================================
// Module : tm_sch_pri_sel
// Brief  : Round-robin queue selector for one priority level of the
//          third-level TM scheduler. Reads the {qid_hi,qid_lo} control word
//          for the requested scheduler, picks the queue after the last one
//          served (wrapping inside the range) and offers it downstream with
//          a valid/ready handshake.
//          Optional statistics counters: define TM_SCH_PRI_SEL_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tm_sch_pri_sel
    import tm_sch_pkg::*;
#(
    parameter int QID_NBITS   = TM_QID_NBITS,
    parameter int SCH_NBITS   = TM_SCH_NBITS,
    parameter int WIDTH       = (QID_NBITS << 1),
    parameter int ACK_TIMEOUT = TM_SEL_ACK_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sch_req,
    input  logic [SCH_NBITS-1:0] sch_id,
    output logic                 sch_rdy,
    output logic                 ctrl_rd,
    output logic [SCH_NBITS-1:0] ctrl_raddr,
    input  logic                 ctrl_ack,
    input  logic [WIDTH-1:0]     ctrl_rdata,
    output logic                 sel_valid,
    input  logic                 sel_ready,
    output logic [QID_NBITS-1:0] sel_qid,
    output logic [SCH_NBITS-1:0] sel_sch_id,
    output logic                 sel_err
`ifdef TM_SCH_PRI_SEL_STATS_EN
    ,
    output logic [31:0]          stat_grant_cnt,
    output logic [15:0]          stat_err_cnt
`endif
);

    // Timeout counter must hold ACK_TIMEOUT-1.
    localparam int c_to_w = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(ACK_TIMEOUT - 1);

    sel_state_e           state_q;
    logic                 sch_rdy_q;
    logic                 ctrl_rd_q;
    logic [SCH_NBITS-1:0] ctrl_raddr_q;
    logic [WIDTH-1:0]     ctrl_q;
    logic [c_to_w-1:0]    to_cnt_q;
    logic                 sel_valid_q;
    logic [QID_NBITS-1:0] sel_qid_q;
    logic [SCH_NBITS-1:0] sel_sch_id_q;
    logic                 sel_err_q;

    logic                 w_hs;
    logic                 w_ram_rd;
    logic                 w_ram_we;
    logic [QID_NBITS-1:0] w_ram_rdata;
    logic                 w_ram_rvld;
    logic [QID_NBITS-1:0] w_hi;
    logic [QID_NBITS-1:0] w_lo;
    logic [QID_NBITS:0]   w_ptr_inc;
    logic [QID_NBITS-1:0] w_pick_qid;
    logic                 w_pick_err;

    assign w_hs = (state_q == S_OUT) && sel_valid_q && sel_ready;

    // The pointer is fetched when the control word arrives so it is ready in
    // CALC; the write happens only on the OUT handshake, so the two never
    // coincide.
    assign w_ram_rd = (state_q == S_WAIT) && ctrl_ack;
    assign w_ram_we = w_hs && !sel_err_q;

    tm_sch_rr_ptr_ram #(
        .AW (SCH_NBITS),
        .DW (QID_NBITS)
    ) u_ptr_ram (
        .clk     (clk),
        .rst     (rst),
        .rd_en_i (w_ram_rd),
        .raddr_i (ctrl_raddr_q),
        .rdata_o (w_ram_rdata),
        .rvld_o  (w_ram_rvld),
        .we_i    (w_ram_we),
        .waddr_i (sel_sch_id_q),
        .wdata_i (sel_qid_q)
    );

    assign w_hi = ctrl_q[WIDTH-1:QID_NBITS];
    assign w_lo = ctrl_q[QID_NBITS-1:0];

    // Round-robin pick: restart at lo when the pointer is unknown or outside
    // [lo,hi). ptr+1 > hi is evaluated one bit wider, which is the same as
    // ptr >= hi and can never overflow even for hi = all-ones.
    always_comb begin
        w_ptr_inc  = {1'b0, w_ram_rdata} + {{QID_NBITS{1'b0}}, 1'b1};
        w_pick_err = (w_hi < w_lo);
        if (w_pick_err) begin
            w_pick_qid = w_lo;
        end else if (!w_ram_rvld || (w_ptr_inc > {1'b0, w_hi}) || (w_ram_rdata < w_lo)) begin
            w_pick_qid = w_lo;
        end else begin
            w_pick_qid = w_ptr_inc[QID_NBITS-1:0];
        end
    end

    // Request sequencer: IDLE -> RD -> WAIT -> CALC -> OUT -> IDLE, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sch_rdy_q    <= 1'b0;
            ctrl_rd_q    <= 1'b0;
            ctrl_raddr_q <= '0;
            ctrl_q       <= '0;
            to_cnt_q     <= '0;
            sel_valid_q  <= 1'b0;
            sel_qid_q    <= '0;
            sel_sch_id_q <= '0;
            sel_err_q    <= 1'b0;
        end else begin
            ctrl_rd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    sch_rdy_q <= 1'b1;
                    if (sch_req && sch_rdy_q) begin
                        ctrl_raddr_q <= sch_id;
                        ctrl_rd_q    <= 1'b1;
                        sch_rdy_q    <= 1'b0;
                        state_q      <= S_RD;
                    end
                end
                S_RD: begin
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (ctrl_ack) begin
                        ctrl_q  <= ctrl_rdata;
                        state_q <= S_CALC;
                    end else if (to_cnt_q == c_to_last) begin
                        sel_valid_q  <= 1'b1;
                        sel_err_q    <= 1'b1;
                        sel_qid_q    <= '0;
                        sel_sch_id_q <= ctrl_raddr_q;
                        state_q      <= S_OUT;
                    end else begin
                        to_cnt_q <= to_cnt_q + c_to_w'(1);
                    end
                end
                S_CALC: begin
                    sel_valid_q  <= 1'b1;
                    sel_err_q    <= w_pick_err;
                    sel_qid_q    <= w_pick_qid;
                    sel_sch_id_q <= ctrl_raddr_q;
                    state_q      <= S_OUT;
                end
                S_OUT: begin
                    if (sel_ready) begin
                        sel_valid_q <= 1'b0;
                        sch_rdy_q   <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sch_rdy    = sch_rdy_q;
    assign ctrl_rd    = ctrl_rd_q;
    assign ctrl_raddr = ctrl_raddr_q;
    assign sel_valid  = sel_valid_q;
    assign sel_qid    = sel_qid_q;
    assign sel_sch_id = sel_sch_id_q;
    assign sel_err    = sel_err_q;

`ifdef TM_SCH_PRI_SEL_STATS_EN
    logic [31:0] grant_cnt_q;
    logic [15:0] err_cnt_q;

    // Saturating grant/error counters, advanced on each OUT handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (w_hs) begin
            if (!sel_err_q && (grant_cnt_q != '1)) begin
                grant_cnt_q <= grant_cnt_q + 32'd1;
            end
            if (sel_err_q && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign stat_grant_cnt = grant_cnt_q;
    assign stat_err_cnt   = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tm_sch_pri_sel.sv
// ============================================================================
// Module : tb_tm_sch_pri_sel
// Brief  : Directed self-checking bench for tm_sch_pri_sel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tm_sch_pri_sel;
    import tm_sch_pkg::*;

    localparam int QW = TM_QID_NBITS;
    localparam int SW = TM_SCH_NBITS;
    localparam int WW = 2 * QW;

    logic          clk = 1'b0;
    logic          rst;
    logic          sch_req;
    logic [SW-1:0] sch_id;
    logic          sch_rdy;
    logic          ctrl_rd;
    logic [SW-1:0] ctrl_raddr;
    logic          ctrl_ack;
    logic [WW-1:0] ctrl_rdata;
    logic          sel_valid;
    logic          sel_ready;
    logic [QW-1:0] sel_qid;
    logic [SW-1:0] sel_sch_id;
    logic          sel_err;
`ifdef TM_SCH_PRI_SEL_STATS_EN
    logic [31:0]   stat_grant_cnt;
    logic [15:0]   stat_err_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tm_sch_pri_sel dut (
        .clk        (clk),
        .rst        (rst),
        .sch_req    (sch_req),
        .sch_id     (sch_id),
        .sch_rdy    (sch_rdy),
        .ctrl_rd    (ctrl_rd),
        .ctrl_raddr (ctrl_raddr),
        .ctrl_ack   (ctrl_ack),
        .ctrl_rdata (ctrl_rdata),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .sel_qid    (sel_qid),
        .sel_sch_id (sel_sch_id),
        .sel_err    (sel_err)
`ifdef TM_SCH_PRI_SEL_STATS_EN
        ,
        .stat_grant_cnt (stat_grant_cnt),
        .stat_err_cnt   (stat_err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a request; lat<0 means the control memory never answers.
    task automatic issue(input int sch, input int hi, input int lo, input int lat, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!sch_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".rdy"}, sch_rdy, 1);
        sch_req = 1'b1;
        sch_id  = SW'(sch);
        @(negedge clk);
        sch_req = 1'b0;
        chk({tag, ".rd"}, ctrl_rd, 1);
        chk({tag, ".raddr"}, ctrl_raddr, sch);
        @(negedge clk);
        chk({tag, ".rd_1cyc"}, ctrl_rd, 0);
        if (lat >= 0) begin
            repeat (lat) @(negedge clk);
            ctrl_rdata = {QW'(hi), QW'(lo)};
            ctrl_ack   = 1'b1;
            @(negedge clk);
            ctrl_ack   = 1'b0;
        end
    endtask

    task automatic expect_sel(input string tag, input int q, input int e, input int sch, input int lat_n);
        int n;
        n = 0;
        while (!sel_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".valid"}, sel_valid, 1);
        chk({tag, ".lat"}, n, lat_n);
        chk({tag, ".qid"}, sel_qid, q);
        chk({tag, ".err"}, sel_err, e);
        chk({tag, ".sch"}, sel_sch_id, sch);
        chk({tag, ".busy"}, sch_rdy, 0);
    endtask

    task automatic accept_sel(input string tag);
        sel_ready = 1'b1;
        @(negedge clk);
        sel_ready = 1'b0;
        chk({tag, ".drop"}, sel_valid, 0);
        chk({tag, ".rdy_back"}, sch_rdy, 1);
    endtask

    task automatic pick(input int sch, input int hi, input int lo, input int q, input int e, input string tag);
        issue(sch, hi, lo, 0, tag);
        expect_sel(tag, q, e, sch, 1);
        accept_sel(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".sch_rdy"}, sch_rdy, 0);
        chk({tag, ".ctrl_rd"}, ctrl_rd, 0);
        chk({tag, ".raddr"}, ctrl_raddr, 0);
        chk({tag, ".valid"}, sel_valid, 0);
        chk({tag, ".qid"}, sel_qid, 0);
        chk({tag, ".sch"}, sel_sch_id, 0);
        chk({tag, ".err"}, sel_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_basic [5];
        exp_basic = '{2, 3, 4, 5, 2};

        rst        = 1'b1;
        sch_req    = 1'b0;
        sch_id     = '0;
        ctrl_ack   = 1'b0;
        ctrl_rdata = '0;
        sel_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Basic round robin inside {hi=5,lo=2}, wrapping back to 2.
        for (int i = 0; i < 5; i++) begin
            pick(3, 5, 2, exp_basic[i], 0, "basic");
        end

        // Independent pointers per scheduler.
        pick(1, 3, 0, 0, 0, "il_s1a");
        pick(2, 9, 8, 8, 0, "il_s2a");
        pick(1, 3, 0, 1, 0, "il_s1b");
        pick(2, 9, 8, 9, 0, "il_s2b");
        pick(1, 3, 0, 2, 0, "il_s1c");
        pick(2, 9, 8, 8, 0, "il_s2c");

        // Single-queue range and all-ones hi.
        pick(6, 7, 7, 7, 0, "single_a");
        pick(6, 7, 7, 7, 0, "single_b");
        pick(7, 255, 254, 254, 0, "top_a");
        pick(7, 255, 254, 255, 0, "top_b");
        pick(7, 255, 254, 254, 0, "top_c");

        // Bad range leaves the pointer untouched.
        pick(4, 1, 4, 4, 1, "bad");
        pick(4, 6, 4, 4, 0, "bad_next_a");
        pick(4, 6, 4, 5, 0, "bad_next_b");

        // Ack timeout, then a late ack that must be ignored.
        issue(5, 0, 0, -1, "tmo");
        expect_sel("tmo", 0, 1, 5, 64);
        accept_sel("tmo");
        ctrl_rdata = {QW'(3), QW'(1)};
        ctrl_ack   = 1'b1;
        @(negedge clk);
        ctrl_ack   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("late_ack.valid", sel_valid, 0);
            chk("late_ack.rd", ctrl_rd, 0);
        end
        pick(5, 2, 1, 1, 0, "after_tmo");

        // Backpressure: outputs hold while sel_ready is low.
        issue(3, 5, 2, 0, "bp");
        expect_sel("bp", 3, 0, 3, 1);
        repeat (10) begin
            @(negedge clk);
            chk("bp.hold_valid", sel_valid, 1);
            chk("bp.hold_qid", sel_qid, 3);
            chk("bp.hold_err", sel_err, 0);
            chk("bp.hold_rdy", sch_rdy, 0);
        end
        accept_sel("bp");

        // Reset while waiting for the control memory.
        issue(3, 5, 2, -1, "rstw");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_wait");
        rst = 1'b0;
        pick(3, 5, 2, 2, 0, "post_rst_s3");
        pick(1, 3, 0, 0, 0, "post_rst_s1");
        pick(2, 9, 8, 8, 0, "post_rst_s2");
        pick(4, 1, 4, 4, 1, "post_rst_bad");

`ifdef TM_SCH_PRI_SEL_STATS_EN
        chk("stat_grant", stat_grant_cnt, 3);
        chk("stat_err", {16'd0, stat_err_cnt}, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
